// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe
//   Pipelined bitwise logic unit for the SHA-256 datapath. Decodes one of
//   NOT/AND/OR/XOR/CH/MAJ/XOR3 on the input side, then carries the result
//   through STAGES elastic register slots with valid/ready on both sides.
//   Empty slots fill behind a stalled head. Capacity is exactly STAGES ops.
//
// Parameters
//   WIDTH   operand/result width (>= 1)
//   STAGES  number of register slots (1..4); latency without backpressure
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high; clears all slots
//   in_valid       upstream op/operands present
//   in_ready       slot 0 can load this cycle
//   op             000 NOT, 001 AND, 010 OR, 011 XOR, 100 CH, 101 MAJ,
//                  110 XOR3, 111 illegal (result 0, err 1)
//   data_operandA  operand A
//   data_operandB  operand B
//   data_operandC  operand C
//   out_valid      head slot holds a result
//   out_ready      downstream accepts the head this cycle
//   data_result    result of the oldest in-flight op
//   out_err        oldest in-flight op had an illegal opcode
module alu_logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [WIDTH-1:0] data_operandC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             out_err
);

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_CH   = 3'b100;
    localparam logic [2:0] OP_MAJ  = 3'b101;
    localparam logic [2:0] OP_XOR3 = 3'b110;

    // Returns {err, result}.
    function automatic logic [WIDTH:0] decode_op(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b,
        input logic [WIDTH-1:0] f_c
    );
        logic [WIDTH:0] f_out;
        f_out = '0;
        case (f_op)
            OP_NOT:  f_out = {1'b0, ~f_a};
            OP_AND:  f_out = {1'b0, f_a & f_b};
            OP_OR:   f_out = {1'b0, f_a | f_b};
            OP_XOR:  f_out = {1'b0, f_a ^ f_b};
            OP_CH:   f_out = {1'b0, (f_a & f_b) ^ (~f_a & f_c)};
            OP_MAJ:  f_out = {1'b0, (f_a & f_b) ^ (f_a & f_c) ^ (f_b & f_c)};
            OP_XOR3: f_out = {1'b0, f_a ^ f_b ^ f_c};
            default: f_out = {1'b1, {WIDTH{1'b0}}};
        endcase
        return f_out;
    endfunction

    logic [STAGES-1:0] r_vld_p;
    logic [STAGES-1:0] r_err_p;
    logic [WIDTH-1:0]  r_res_p [STAGES];

    logic [STAGES-1:0] w_load;
    logic              w_acc;
    logic [WIDTH-1:0]  w_dec_res;
    logic              w_dec_err;

    always_comb begin
        {w_dec_err, w_dec_res} = decode_op(op, data_operandA, data_operandB, data_operandC);
    end

    // Slot i may load when out_ready is high or any slot at or after i is
    // empty. Built from the head backwards so no load bit depends on another
    // load bit; in_valid never enters this chain.
    always_comb begin
        w_load = '0;
        w_acc  = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc     = w_acc | ~r_vld_p[i];
            w_load[i] = w_acc;
        end
    end

    assign in_ready = w_load[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p <= '0;
            r_err_p <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_res_p[i] <= '0;
            end
        end else begin
            // Slot 0: captures decoded input; payload only on a real transfer
            if (w_load[0]) begin
                r_vld_p[0] <= in_valid;
                if (in_valid) begin
                    r_res_p[0] <= w_dec_res;
                    r_err_p[0] <= w_dec_err;
                end
            end
            // Slots 1..STAGES-1: shift forward; an empty predecessor leaves a bubble
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld_p[i] <= r_vld_p[i-1];
                    if (r_vld_p[i-1]) begin
                        r_res_p[i] <= r_res_p[i-1];
                        r_err_p[i] <= r_err_p[i-1];
                    end
                end
            end
        end
    end

    // Head slot drives the outputs
    assign out_valid   = r_vld_p[STAGES-1];
    assign data_result = r_res_p[STAGES-1];
    assign out_err     = r_err_p[STAGES-1];

endmodule

// File: tb/tb_alu_logic_pipe.sv
module tb_alu_logic_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [31:0] a, b, c;

    int          sel;
    int          cur_stages;
    logic [31:0] cur_mask;

    int n_tests = 0;
    int n_fail  = 0;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        er0, er1, er2;
    logic [31:0] res0, res2;
    logic [7:0]  res1;

    logic        m_ir, m_ov, m_err;
    logic [31:0] m_res;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    always_comb begin
        m_ir = ir0; m_ov = ov0; m_err = er0; m_res = res0;
        case (sel)
            1: begin m_ir = ir1; m_ov = ov1; m_err = er1; m_res = {24'h0, res1}; end
            2: begin m_ir = ir2; m_ov = ov2; m_err = er2; m_res = res2; end
            default: ;
        endcase
    end

    alu_logic_pipe #(.WIDTH(32), .STAGES(2)) u_d0 (
        .clock(clk), .reset(rst), .in_valid(iv0), .in_ready(ir0), .op(op),
        .data_operandA(a), .data_operandB(b), .data_operandC(c),
        .out_valid(ov0), .out_ready(out_ready), .data_result(res0), .out_err(er0));

    alu_logic_pipe #(.WIDTH(8), .STAGES(1)) u_d1 (
        .clock(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .op(op),
        .data_operandA(a[7:0]), .data_operandB(b[7:0]), .data_operandC(c[7:0]),
        .out_valid(ov1), .out_ready(out_ready), .data_result(res1), .out_err(er1));

    alu_logic_pipe #(.WIDTH(32), .STAGES(4)) u_d2 (
        .clock(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2), .op(op),
        .data_operandA(a), .data_operandB(b), .data_operandC(c),
        .out_valid(ov2), .out_ready(out_ready), .data_result(res2), .out_err(er2));

    // Drive one op, wait for acceptance, return the result and latency
    // (cycles from the accepting edge to the cycle out_valid is seen).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, y, z,
                          output logic [31:0] r, output logic e, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; c = z; out_ready = 1'b1;
        n = 0;
        while (!m_ir && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 3'b111; a = '1; b = '1; c = '1;
        lat = -1; r = '0; e = 1'b0;
        n = 0;
        while (lat < 0 && n < 10) begin
            @(negedge clk);
            n++;
            if (m_ov) begin
                lat = n; r = m_res; e = m_err;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL reset[%0d] out_valid: got %b expected 0", sel, m_ov); end
        n_tests++;
        if (m_res !== 32'h0) begin n_fail++; $display("FAIL reset[%0d] data_result: got %h expected 0", sel, m_res); end
        n_tests++;
        if (m_err !== 1'b0) begin n_fail++; $display("FAIL reset[%0d] out_err: got %b expected 0", sel, m_err); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (m_ir !== 1'b1) begin n_fail++; $display("FAIL reset[%0d] in_ready: got %b expected 1", sel, m_ir); end
    endtask

    task automatic test_not_latency();
        logic [31:0] r; logic e; int lat;
        run_op(3'b000, 32'hA5A5A5A5, 32'h0, 32'h0, r, e, lat);
        n_tests++;
        if (lat != cur_stages) begin n_fail++; $display("FAIL not_latency[%0d]: got %0d expected %0d", sel, lat, cur_stages); end
        n_tests++;
        if (r !== (32'h5A5A5A5A & cur_mask)) begin
            n_fail++; $display("FAIL not_result[%0d]: got %h expected %h", sel, r, 32'h5A5A5A5A & cur_mask);
        end
        n_tests++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL not_err[%0d]: got %b expected 0", sel, e); end
    endtask

    task automatic test_ops();
        logic [2:0]  to [6];
        logic [31:0] ta [6], tb [6], tc [6], te [6];
        logic [31:0] r; logic e; int lat;
        to[0] = 3'b001; ta[0] = 32'hFFFF0000; tb[0] = 32'h12345678; tc[0] = 32'h9ABCDEF0; te[0] = 32'h12340000;
        to[1] = 3'b010; ta[1] = 32'hFFFF0000; tb[1] = 32'h12345678; tc[1] = 32'h9ABCDEF0; te[1] = 32'hFFFF5678;
        to[2] = 3'b011; ta[2] = 32'hFFFF0000; tb[2] = 32'h12345678; tc[2] = 32'h9ABCDEF0; te[2] = 32'hEDCB5678;
        to[3] = 3'b100; ta[3] = 32'hFFFF0000; tb[3] = 32'h12345678; tc[3] = 32'h9ABCDEF0; te[3] = 32'h1234DEF0;
        to[4] = 3'b101; ta[4] = 32'hF0F0F0F0; tb[4] = 32'hFF00FF00; tc[4] = 32'h00FF00FF; te[4] = 32'hF0F0F0F0;
        to[5] = 3'b110; ta[5] = 32'h0F0F0F0F; tb[5] = 32'h00FF00FF; tc[5] = 32'hFFFF0000; te[5] = 32'hF00F0FF0;
        for (int i = 0; i < 6; i++) begin
            run_op(to[i], ta[i], tb[i], tc[i], r, e, lat);
            n_tests++;
            if (r !== (te[i] & cur_mask) || lat != cur_stages) begin
                n_fail++;
                $display("FAIL ops[%0d] op=%b: got %h lat %0d expected %h lat %0d", i, to[i], r, lat, te[i] & cur_mask, cur_stages);
            end
            n_tests++;
            if (e !== 1'b0) begin n_fail++; $display("FAIL ops_err[%0d]: got %b expected 0", i, e); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] r; logic e; int lat;
        run_op(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, r, e, lat);
        n_tests++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL illegal_result: got %h expected 00000000", r); end
        n_tests++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", e); end
        run_op(3'b001, 32'hFFFF0000, 32'h12345678, 32'h0, r, e, lat);
        n_tests++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL illegal_next_err: got %b expected 0", e); end
        n_tests++;
        if (r !== 32'h12340000) begin n_fail++; $display("FAIL illegal_next_result: got %h expected 12340000", r); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  vo [8];
        logic [31:0] va [8], vb [8], vc [8], ve [8];
        int   in_idx, out_idx, occ, max_occ, cyc;
        bit   saw_block;
        logic acc, drn, exp_ir;
        vo[0] = 3'b001; va[0] = 32'hFFFF0000; vb[0] = 32'h12345678; vc[0] = 32'h9ABCDEF0; ve[0] = 32'h12340000;
        vo[1] = 3'b010; va[1] = 32'hFFFF0000; vb[1] = 32'h12345678; vc[1] = 32'h9ABCDEF0; ve[1] = 32'hFFFF5678;
        vo[2] = 3'b011; va[2] = 32'hFFFF0000; vb[2] = 32'h12345678; vc[2] = 32'h9ABCDEF0; ve[2] = 32'hEDCB5678;
        vo[3] = 3'b000; va[3] = 32'hA5A5A5A5; vb[3] = 32'h0;        vc[3] = 32'h0;        ve[3] = 32'h5A5A5A5A;
        vo[4] = 3'b100; va[4] = 32'hFFFF0000; vb[4] = 32'h12345678; vc[4] = 32'h9ABCDEF0; ve[4] = 32'h1234DEF0;
        vo[5] = 3'b101; va[5] = 32'hF0F0F0F0; vb[5] = 32'hFF00FF00; vc[5] = 32'h00FF00FF; ve[5] = 32'hF0F0F0F0;
        vo[6] = 3'b110; va[6] = 32'h0F0F0F0F; vb[6] = 32'h00FF00FF; vc[6] = 32'hFFFF0000; ve[6] = 32'hF00F0FF0;
        vo[7] = 3'b000; va[7] = 32'h00000000; vb[7] = 32'h0;        vc[7] = 32'h0;        ve[7] = 32'hFFFFFFFF;
        in_idx = 0; out_idx = 0; occ = 0; max_occ = 0; saw_block = 1'b0; cyc = 0;
        while (cyc < 60 && out_idx < 8) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 7);
            if (in_idx < 8) begin
                in_valid = 1'b1; op = vo[in_idx]; a = va[in_idx]; b = vb[in_idx]; c = vc[in_idx];
            end else begin
                in_valid = 1'b0; op = 3'b111; a = '1; b = '1; c = '1;
            end
            #1;
            exp_ir = (occ < cur_stages) || out_ready;
            n_tests++;
            if (m_ir !== exp_ir) begin
                n_fail++; $display("FAIL b2b_in_ready[%0d] cycle %0d: got %b expected %b", sel, cyc, m_ir, exp_ir);
            end
            if (!m_ir) saw_block = 1'b1;
            if (m_ov) begin
                n_tests++;
                if (m_res !== (ve[out_idx] & cur_mask) || m_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d] idx %0d cycle %0d: got %h/%b expected %h/0",
                             sel, out_idx, cyc, m_res, m_err, ve[out_idx] & cur_mask);
                end
            end
            acc = in_valid && m_ir;
            drn = m_ov && out_ready;
            occ = occ + int'(acc) - int'(drn);
            if (occ > max_occ) max_occ = occ;
            in_idx  = in_idx + int'(acc);
            out_idx = out_idx + int'(drn);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (out_idx != 8) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 8", sel, out_idx); end
        n_tests++;
        if (!saw_block) begin n_fail++; $display("FAIL b2b_backpressure[%0d]: in_ready never dropped, expected a drop", sel); end
        n_tests++;
        if (max_occ != cur_stages) begin n_fail++; $display("FAIL b2b_capacity[%0d]: got %0d expected %0d", sel, max_occ, cur_stages); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_ov !== 1'b0) begin n_fail++; $display("FAIL b2b_extra[%0d]: out_valid got %b expected 0", sel, m_ov); end
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b000; a = 32'hA5A5A5A5; b = 32'h0; c = 32'h0;
        @(negedge clk);
        op = 3'b001; a = 32'hFFFF0000; b = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (m_ov !== 1'b1) begin n_fail++; $display("FAIL midreset_loaded: out_valid got %b expected 1", m_ov); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", m_ov); end
        n_tests++;
        if (m_res !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected 0", m_res); end
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (m_ir !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", m_ir); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_ov) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL midreset_ghost: got %0d outputs expected 0", seen); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'b000;
        a = '0; b = '0; c = '0;
        sel = 0; cur_stages = 2; cur_mask = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);

        test_reset();
        test_not_latency();
        test_ops();
        test_illegal();
        test_back_to_back();
        test_reset_midstream();

        sel = 1; cur_stages = 1; cur_mask = 32'h000000FF;
        test_reset();
        test_not_latency();
        test_back_to_back();

        sel = 2; cur_stages = 4; cur_mask = 32'hFFFFFFFF;
        test_reset();
        test_not_latency();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
